// File: rtl/mem_burst_sched.sv
// Burst scheduler: round-robin write/read bursts between the capture/display FIFOs and mem_burst.
// Generates wrapping frame-buffer addresses and steers burst data combinationally.
`timescale 1ns / 1ps

module mem_burst_sched #(
  parameter int unsigned MEM_DATA_BITS = 64,
  parameter int unsigned ADDR_BITS     = 24,
  parameter int unsigned BURST_LEN     = 64,
  parameter int unsigned FRAME_WORDS   = 786432,
  parameter int unsigned WR_BASE       = 0,
  parameter int unsigned RD_BASE       = 0,
  parameter int unsigned FIFO_DEPTH    = 1024
) (
  input  logic                     mem_clk,
  input  logic                     rst,
  input  logic                     init_calib_complete,
  input  logic                     wr_frame_start,
  input  logic                     rd_frame_start,
  input  logic [10:0]              wr_fifo_level,
  input  logic [MEM_DATA_BITS-1:0] wr_fifo_q,
  output logic                     wr_fifo_rd,
  input  logic [10:0]              rd_fifo_level,
  output logic                     rd_fifo_wr,
  output logic [MEM_DATA_BITS-1:0] rd_fifo_data,
  output logic                     wr_frame_done,
  output logic                     rd_frame_done,
  output logic                     rd_burst_req,
  output logic                     wr_burst_req,
  output logic [9:0]               rd_burst_len,
  output logic [9:0]               wr_burst_len,
  output logic [ADDR_BITS-1:0]     rd_burst_addr,
  output logic [ADDR_BITS-1:0]     wr_burst_addr,
  input  logic                     rd_burst_data_valid,
  input  logic [MEM_DATA_BITS-1:0] rd_burst_data,
  input  logic                     wr_burst_data_req,
  output logic [MEM_DATA_BITS-1:0] wr_burst_data,
  input  logic                     rd_burst_finish,
  input  logic                     wr_burst_finish
);

  typedef enum logic [1:0] {StIdle, StWrBurst, StRdBurst, StGap} state_e;

  localparam logic [11:0]          BurstLen12 = 12'(BURST_LEN);
  localparam logic [11:0]          Depth12    = 12'(FIFO_DEPTH);
  localparam logic [ADDR_BITS-1:0] BurstStep  = ADDR_BITS'(BURST_LEN);
  localparam logic [ADDR_BITS-1:0] LastOff    = ADDR_BITS'(FRAME_WORDS - BURST_LEN);
  localparam logic [ADDR_BITS-1:0] WrBase     = ADDR_BITS'(WR_BASE);
  localparam logic [ADDR_BITS-1:0] RdBase     = ADDR_BITS'(RD_BASE);

  state_e               state_q, state_d;
  logic [ADDR_BITS-1:0] wr_off_q, wr_off_d, rd_off_q, rd_off_d;
  logic                 last_wr_q, last_wr_d;
  logic                 wr_pend_q, wr_pend_d, rd_pend_q, rd_pend_d;
  logic                 gap_q, gap_d;
  logic                 wr_done_d, rd_done_d;
  logic                 wr_req_q, rd_req_q, wr_done_q, rd_done_q;
  logic [ADDR_BITS-1:0] wr_addr_q, rd_addr_q;
  logic [11:0]          rd_lvl;
  logic                 wr_ok, rd_ok;

  assign rd_lvl = {1'b0, rd_fifo_level};
  assign wr_ok  = {1'b0, wr_fifo_level} >= BurstLen12;
  // Guard the subtraction so an over-full level can never underflow into "lots of space".
  assign rd_ok  = (rd_lvl <= Depth12) && ((Depth12 - rd_lvl) >= BurstLen12);

  always_comb begin
    state_d   = state_q;
    wr_off_d  = wr_off_q;
    rd_off_d  = rd_off_q;
    last_wr_d = last_wr_q;
    wr_pend_d = wr_pend_q;
    rd_pend_d = rd_pend_q;
    gap_d     = 1'b0;
    wr_done_d = 1'b0;
    rd_done_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (init_calib_complete) begin
          if (wr_ok && (!rd_ok || !last_wr_q)) begin
            state_d = StWrBurst;
          end else if (rd_ok) begin
            state_d = StRdBurst;
          end
        end
      end
      StWrBurst: begin
        if (wr_burst_finish) begin
          state_d   = StGap;
          last_wr_d = 1'b1;
          wr_pend_d = 1'b0;
          wr_done_d = (wr_off_q == LastOff);
          if (wr_pend_q || wr_frame_start || (wr_off_q == LastOff)) begin
            wr_off_d = '0;
          end else begin
            wr_off_d = wr_off_q + BurstStep;
          end
        end
      end
      StRdBurst: begin
        if (rd_burst_finish) begin
          state_d   = StGap;
          last_wr_d = 1'b0;
          rd_pend_d = 1'b0;
          rd_done_d = (rd_off_q == LastOff);
          if (rd_pend_q || rd_frame_start || (rd_off_q == LastOff)) begin
            rd_off_d = '0;
          end else begin
            rd_off_d = rd_off_q + BurstStep;
          end
        end
      end
      StGap: begin
        gap_d = ~gap_q;
        if (gap_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // A restart during the channel's own burst waits for finish so the address stays stable.
    if (wr_frame_start) begin
      if (state_q == StWrBurst) begin
        if (!wr_burst_finish) begin
          wr_pend_d = 1'b1;
        end
      end else begin
        wr_off_d = '0;
      end
    end
    if (rd_frame_start) begin
      if (state_q == StRdBurst) begin
        if (!rd_burst_finish) begin
          rd_pend_d = 1'b1;
        end
      end else begin
        rd_off_d = '0;
      end
    end
  end

  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      wr_off_q  <= '0;
      rd_off_q  <= '0;
      last_wr_q <= 1'b0;
      wr_pend_q <= 1'b0;
      rd_pend_q <= 1'b0;
      gap_q     <= 1'b0;
      wr_req_q  <= 1'b0;
      rd_req_q  <= 1'b0;
      wr_done_q <= 1'b0;
      rd_done_q <= 1'b0;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_off_q  <= wr_off_d;
      rd_off_q  <= rd_off_d;
      last_wr_q <= last_wr_d;
      wr_pend_q <= wr_pend_d;
      rd_pend_q <= rd_pend_d;
      gap_q     <= gap_d;
      wr_req_q  <= (state_d == StWrBurst);
      rd_req_q  <= (state_d == StRdBurst);
      wr_done_q <= wr_done_d;
      rd_done_q <= rd_done_d;
      // Built from next-state offsets so the address is valid on the same edge as the request.
      wr_addr_q <= WrBase + wr_off_d;
      rd_addr_q <= RdBase + rd_off_d;
    end
  end

  assign wr_burst_req  = wr_req_q;
  assign rd_burst_req  = rd_req_q;
  assign wr_burst_addr = wr_addr_q;
  assign rd_burst_addr = rd_addr_q;
  assign wr_frame_done = wr_done_q;
  assign rd_frame_done = rd_done_q;
  assign wr_burst_len  = 10'(BURST_LEN);
  assign rd_burst_len  = 10'(BURST_LEN);

  assign wr_fifo_rd    = wr_burst_data_req & (state_q == StWrBurst);
  assign wr_burst_data = wr_fifo_q;
  assign rd_fifo_wr    = rd_burst_data_valid & (state_q == StRdBurst);
  assign rd_fifo_data  = rd_burst_data;

endmodule

// File: tb/tb_mem_burst_sched.sv
// Scoreboard bench for mem_burst_sched: stimulus queues expected bursts, a monitor checks them
// as requests appear, and a behavioural mem_burst model completes each burst.
`timescale 1ns / 1ps

module tb_mem_burst_sched;

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 24;
  localparam int unsigned BL = 64;
  localparam int unsigned FW = 256;
  localparam int unsigned WB = 0;
  localparam int unsigned RB = 4096;
  localparam int unsigned FD = 1024;

  logic          mem_clk;
  logic          rst;
  logic          init_calib_complete;
  logic          wr_frame_start, rd_frame_start;
  logic [10:0]   wr_fifo_level, rd_fifo_level;
  logic [DW-1:0] wr_fifo_q;
  logic          wr_fifo_rd, rd_fifo_wr;
  logic [DW-1:0] rd_fifo_data;
  logic          wr_frame_done, rd_frame_done;
  logic          rd_burst_req, wr_burst_req;
  logic [9:0]    rd_burst_len, wr_burst_len;
  logic [AW-1:0] rd_burst_addr, wr_burst_addr;
  logic          rd_burst_data_valid;
  logic [DW-1:0] rd_burst_data;
  logic          wr_burst_data_req;
  logic [DW-1:0] wr_burst_data;
  logic          rd_burst_finish, wr_burst_finish;

  mem_burst_sched #(
    .MEM_DATA_BITS(DW),
    .ADDR_BITS    (AW),
    .BURST_LEN    (BL),
    .FRAME_WORDS  (FW),
    .WR_BASE      (WB),
    .RD_BASE      (RB),
    .FIFO_DEPTH   (FD)
  ) dut (
    .mem_clk            (mem_clk),
    .rst                (rst),
    .init_calib_complete(init_calib_complete),
    .wr_frame_start     (wr_frame_start),
    .rd_frame_start     (rd_frame_start),
    .wr_fifo_level      (wr_fifo_level),
    .wr_fifo_q          (wr_fifo_q),
    .wr_fifo_rd         (wr_fifo_rd),
    .rd_fifo_level      (rd_fifo_level),
    .rd_fifo_wr         (rd_fifo_wr),
    .rd_fifo_data       (rd_fifo_data),
    .wr_frame_done      (wr_frame_done),
    .rd_frame_done      (rd_frame_done),
    .rd_burst_req       (rd_burst_req),
    .wr_burst_req       (wr_burst_req),
    .rd_burst_len       (rd_burst_len),
    .wr_burst_len       (wr_burst_len),
    .rd_burst_addr      (rd_burst_addr),
    .wr_burst_addr      (wr_burst_addr),
    .rd_burst_data_valid(rd_burst_data_valid),
    .rd_burst_data      (rd_burst_data),
    .wr_burst_data_req  (wr_burst_data_req),
    .wr_burst_data      (wr_burst_data),
    .rd_burst_finish    (rd_burst_finish),
    .wr_burst_finish    (wr_burst_finish)
  );

  initial mem_clk = 1'b0;
  always #5 mem_clk = ~mem_clk;

  typedef struct packed {
    logic          is_wr;
    logic [AW-1:0] addr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   req_rises = 0;
  int   wr_pops = 0, rd_pushes = 0;
  int   wr_done_pulses = 0, wr_done_cycles = 0, rd_done_pulses = 0, rd_done_cycles = 0;
  logic prev_wr_req = 1'b0, prev_rd_req = 1'b0, prev_wr_done = 1'b0, prev_rd_done = 1'b0;
  int   resp_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic w, input int unsigned a);
    exp_t e;
    e.is_wr = w;
    e.addr  = AW'(a);
    return e;
  endfunction

  // Monitor: pops the scoreboard on each new request and tracks per-burst data transfers.
  initial begin
    forever begin
      @(negedge mem_clk);
      if (rst) begin
        prev_wr_req  = 1'b0;
        prev_rd_req  = 1'b0;
        prev_wr_done = 1'b0;
        prev_rd_done = 1'b0;
      end else begin
        if ((wr_burst_req && !prev_wr_req) || (rd_burst_req && !prev_rd_req)) begin
          req_rises++;
          wr_pops   = 0;
          rd_pushes = 0;
          check("req_exclusive", 64'(wr_burst_req & rd_burst_req), 64'd0);
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_req: wr=%0b rd=%0b wr_addr=0x%0h rd_addr=0x%0h, none expected",
                     wr_burst_req, rd_burst_req, wr_burst_addr, rd_burst_addr);
          end else begin
            mon_e = exp_q.pop_front();
            check("req_dir", 64'(wr_burst_req), 64'(mon_e.is_wr));
            check("req_addr", 64'(wr_burst_req ? wr_burst_addr : rd_burst_addr), 64'(mon_e.addr));
            check("req_len", 64'(wr_burst_req ? wr_burst_len : rd_burst_len), 64'(BL));
          end
        end
        if (wr_fifo_rd) begin
          wr_pops++;
          check("wr_data_steer", wr_burst_data, wr_fifo_q);
        end
        if (rd_fifo_wr) begin
          rd_pushes++;
          check("rd_data_steer", rd_fifo_data, rd_burst_data);
        end
        if (!wr_burst_req && prev_wr_req) begin
          check("wr_pop_count", 64'(wr_pops), 64'(BL));
          check("rd_push_in_wr", 64'(rd_pushes), 64'd0);
        end
        if (!rd_burst_req && prev_rd_req) begin
          check("rd_push_count", 64'(rd_pushes), 64'(BL));
          check("wr_pop_in_rd", 64'(wr_pops), 64'd0);
        end
        if (wr_frame_done) begin
          wr_done_cycles++;
          if (!prev_wr_done) wr_done_pulses++;
        end
        if (rd_frame_done) begin
          rd_done_cycles++;
          if (!prev_rd_done) rd_done_pulses++;
        end
        prev_wr_req  = wr_burst_req;
        prev_rd_req  = rd_burst_req;
        prev_wr_done = wr_frame_done;
        prev_rd_done = rd_frame_done;
      end
    end
  end

  // mem_burst model: BL data beats, then a one-cycle finish, for whichever request is high.
  initial begin
    wr_burst_data_req   = 1'b0;
    rd_burst_data_valid = 1'b0;
    wr_burst_finish     = 1'b0;
    rd_burst_finish     = 1'b0;
    wr_fifo_q           = '0;
    rd_burst_data       = '0;
    forever begin
      @(posedge mem_clk);
      #1;
      wr_fifo_q     = wr_fifo_q + 64'h0101_0101_0101_0101;
      rd_burst_data = {$urandom, $urandom};
      wr_burst_data_req   = 1'b0;
      rd_burst_data_valid = 1'b0;
      wr_burst_finish     = 1'b0;
      rd_burst_finish     = 1'b0;
      if (rst || (!wr_burst_req && !rd_burst_req)) begin
        resp_cnt = 0;
      end else if (resp_cnt < int'(BL)) begin
        wr_burst_data_req   = wr_burst_req;
        rd_burst_data_valid = rd_burst_req;
        resp_cnt++;
      end else begin
        wr_burst_finish = wr_burst_req;
        rd_burst_finish = rd_burst_req;
      end
    end
  end

  task automatic cycle();
    @(posedge mem_clk);
    #1;
  endtask

  task automatic wait_rises(input int n);
    int t = 0;
    while (req_rises < n && t < 2000) begin
      cycle();
      t++;
    end
    checks++;
    if (req_rises < n) begin
      failures++;
      $display("FAIL wait_req: saw %0d requests, expected %0d", req_rises, n);
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((wr_burst_req || rd_burst_req) && t < 2000) begin
      cycle();
      t++;
    end
    checks++;
    if (wr_burst_req || rd_burst_req) begin
      failures++;
      $display("FAIL wait_idle: request still high wr=%0b rd=%0b", wr_burst_req, rd_burst_req);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge mem_clk);
    check("rst_wr_req", 64'(wr_burst_req), 64'd0);
    check("rst_rd_req", 64'(rd_burst_req), 64'd0);
    check("rst_wr_done", 64'(wr_frame_done), 64'd0);
    check("rst_rd_done", 64'(rd_frame_done), 64'd0);
    cycle();
    rst = 1'b0;
    exp_q.delete();
    req_rises      = 0;
    wr_done_pulses = 0;
    wr_done_cycles = 0;
    rd_done_pulses = 0;
    rd_done_cycles = 0;
    cycle();
    check("rst_wr_addr", 64'(wr_burst_addr), 64'(WB));
    check("rst_rd_addr", 64'(rd_burst_addr), 64'(RB));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst                 = 1'b1;
    init_calib_complete = 1'b0;
    wr_frame_start      = 1'b0;
    rd_frame_start      = 1'b0;
    wr_fifo_level       = 11'd200;
    rd_fifo_level       = 11'd1024;
    cycle();

    // Uncalibrated: no request despite a full write FIFO, then 1-cycle request latency.
    do_reset();
    repeat (50) cycle();
    check("no_req_uncal", 64'(req_rises), 64'd0);
    exp_q.push_back(mk(1'b1, WB));
    init_calib_complete = 1'b1;
    @(negedge mem_clk);
    check("calib_latency_early", 64'(wr_burst_req), 64'd0);
    @(negedge mem_clk);
    check("calib_latency", 64'(wr_burst_req), 64'd1);
    cycle();
    wr_fifo_level = 11'd0;
    wait_idle();

    // Both eligible and held: round-robin W, R, W, R with write winning the first tie.
    wr_fifo_level = 11'd0;
    rd_fifo_level = 11'd1024;
    do_reset();
    exp_q.push_back(mk(1'b1, WB));
    exp_q.push_back(mk(1'b0, RB));
    exp_q.push_back(mk(1'b1, WB + BL));
    exp_q.push_back(mk(1'b0, RB + BL));
    wr_fifo_level = 11'd100;
    rd_fifo_level = 11'd0;
    wait_rises(4);
    wr_fifo_level = 11'd0;
    rd_fifo_level = 11'd1024;
    wait_idle();
    check("alt_drained", 64'(exp_q.size()), 64'd0);

    // Read space boundary: 961 stored leaves 63 free, 960 leaves exactly one burst.
    rd_fifo_level = 11'd961;
    repeat (20) cycle();
    check("rd_961_blocked", 64'(req_rises), 64'd4);
    exp_q.push_back(mk(1'b0, RB + 2 * BL));
    rd_fifo_level = 11'd960;
    wait_rises(5);
    rd_fifo_level = 11'd1024;
    repeat (3) cycle();
    rd_frame_start = 1'b1;
    cycle();
    rd_frame_start = 1'b0;
    wait_idle();
    exp_q.push_back(mk(1'b0, RB));
    rd_fifo_level = 11'd0;
    wait_rises(6);
    rd_fifo_level = 11'd1024;
    wait_idle();
    check("rd_restart_no_done", 64'(rd_done_pulses), 64'd0);

    // Frame wrap with FRAME_WORDS = 4 bursts.
    do_reset();
    exp_q.push_back(mk(1'b1, WB));
    exp_q.push_back(mk(1'b1, WB + BL));
    exp_q.push_back(mk(1'b1, WB + 2 * BL));
    exp_q.push_back(mk(1'b1, WB + 3 * BL));
    exp_q.push_back(mk(1'b1, WB));
    wr_fifo_level = 11'd100;
    wait_rises(4);
    check("wr_done_before_wrap", 64'(wr_done_pulses), 64'd0);
    wait_rises(5);
    wr_fifo_level = 11'd0;
    wait_idle();
    check("wr_done_pulses", 64'(wr_done_pulses), 64'd1);
    check("wr_done_width", 64'(wr_done_cycles), 64'd1);
    check("rd_done_idle", 64'(rd_done_pulses), 64'd0);

    // Reset mid-write-burst abandons it and returns both offsets to zero.
    exp_q.push_back(mk(1'b1, WB + BL));
    wr_fifo_level = 11'd100;
    wait_rises(6);
    wr_fifo_level = 11'd0;
    repeat (5) cycle();
    do_reset();
    exp_q.push_back(mk(1'b1, WB));
    wr_fifo_level = 11'd100;
    wait_rises(1);
    wr_fifo_level = 11'd0;
    wait_idle();
    check("final_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
